// File: rtl/spi_fifo_bridge.sv
// Wishbone-slave TX/RX word FIFOs feeding the SPI shift stage, one transfer per go/done handshake.
// Optional interrupt output and CTRL.ie bit: define SPI_FIFO_BRIDGE_IRQ_EN.
module spi_fifo_bridge #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [1:0]    wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [DW-1:0] o_tx_data,
    output logic          o_go,
    input  logic          i_done,
    input  logic [DW-1:0] i_rx_data
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    ,
    output logic          wb_int_o
`endif
);

    localparam logic [AW:0]   LP_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t        r_state;
    logic          r_go;
    logic [DW-1:0] r_tx_data;

    logic [DW-1:0] r_tx_mem [DEPTH];
    logic [DW-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [AW:0]   r_tx_cnt, r_rx_cnt;

    logic          r_ack, r_err;
    logic [31:0]   r_dat;
    logic          r_en;
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    logic          r_ie;
    logic          r_int;
`endif

    logic          w_req, w_dat_wr, w_dat_rd, w_ctrl_wr, w_clr;
    logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_busy;
    logic          w_tx_push, w_rx_pop, w_rx_push, w_start, w_bus_err;
    logic [31:0]   w_status, w_ctrl_rd, w_rd_data;
    logic          w_unused_sel;

    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_dat_wr   = w_req & wb_we_i & (wb_adr_i == 2'd0);
    assign w_dat_rd   = w_req & ~wb_we_i & (wb_adr_i == 2'd0);
    assign w_ctrl_wr  = w_req & wb_we_i & (wb_adr_i == 2'd2) & wb_sel_i[0];
    assign w_clr      = w_ctrl_wr & wb_dat_i[1];

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == LP_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == LP_FULL);
    assign w_busy     = (r_state == ST_BUSY);

    assign w_tx_push  = w_dat_wr & ~w_tx_full;
    assign w_rx_pop   = w_dat_rd & ~w_rx_empty;
    assign w_rx_push  = w_busy & i_done;
    // Decision uses registered counts; a same-edge clr suppresses the start and its TX pop.
    assign w_start    = ~w_busy & r_en & ~w_tx_empty & ~w_rx_full & ~w_clr;
    assign w_bus_err  = (w_dat_wr & w_tx_full) | (w_dat_rd & w_rx_empty);

    assign w_status = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt), 3'b000,
                       w_busy, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    assign w_ctrl_rd = {29'd0, r_ie, 1'b0, r_en};
`else
    assign w_ctrl_rd = {31'd0, r_en};
`endif

    assign w_unused_sel = &{1'b0, wb_sel_i[3:1]};

    always_comb begin
        w_rd_data = '0;
        case (wb_adr_i)
            2'd0:    w_rd_data = 32'(r_rx_mem[r_rx_rp]);
            2'd1:    w_rd_data = w_status;
            2'd2:    w_rd_data = w_ctrl_rd;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & ~w_bus_err;
            r_err <= w_bus_err;
            r_dat <= (w_req & ~wb_we_i & ~w_bus_err) ? w_rd_data : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_en <= 1'b0;
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
            r_ie <= 1'b0;
`endif
        end else if (w_ctrl_wr) begin
            r_en <= wb_dat_i[0];
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
            r_ie <= wb_dat_i[2];
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= wb_dat_i[DW-1:0];
        if (w_rx_push)
            r_rx_mem[w_clr ? '0 : r_rx_wp] <= i_rx_data;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else if (w_clr) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wp <= r_tx_wp + LP_PTR_ONE;
            if (w_start)
                r_tx_rp <= r_tx_rp + LP_PTR_ONE;
            case ({w_tx_push, w_start})
                2'b10:   r_tx_cnt <= r_tx_cnt + LP_CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - LP_CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // A completion landing on the clr edge becomes the sole entry of the emptied RX FIFO.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else if (w_clr) begin
            r_rx_rp  <= '0;
            r_rx_wp  <= w_rx_push ? LP_PTR_ONE : '0;
            r_rx_cnt <= w_rx_push ? LP_CNT_ONE : '0;
        end else begin
            if (w_rx_push)
                r_rx_wp <= r_rx_wp + LP_PTR_ONE;
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + LP_PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + LP_CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - LP_CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_go      <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_go      <= 1'b1;
                        r_tx_data <= r_tx_mem[r_tx_rp];
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_done) begin
                        r_go    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            r_int <= 1'b0;
        else
            r_int <= r_ie & (~w_rx_empty | (w_tx_empty & ~w_busy));
    end

    assign wb_int_o = r_int;
`endif

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_dat_o  = r_dat;
    assign o_go      = r_go;
    assign o_tx_data = r_tx_data;

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Directed bench for spi_fifo_bridge: bus register map, FIFO limits, shifter handshake and clr.
module tb_spi_fifo_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] o_tx_data;
    logic        o_go;
    logic        i_done = 1'b0;
    logic [31:0] i_rx_data = '0;
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    logic        wb_int_o;
`endif

    int checks = 0;
    int failures = 0;

    spi_fifo_bridge #(.DW(32), .DEPTH(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_adr_i (adr_i),
        .wb_dat_i (dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (sel_i),
        .wb_we_i  (we_i),
        .wb_stb_i (stb_i),
        .wb_cyc_i (cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .o_tx_data(o_tx_data),
        .o_go     (o_go),
        .i_done   (i_done),
        .i_rx_data(i_rx_data)
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
        ,
        .wb_int_o (wb_int_o)
`endif
    );

    always #5 clk = ~clk;

    // Shifter model: answers each go with ~tx_data about 10 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (o_go) begin
                repeat (9) @(negedge clk);
                i_rx_data = ~o_tx_data;
                i_done = 1'b1;
                @(negedge clk);
                i_done = 1'b0;
            end
        end
    end

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            output logic ack, output logic err);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = adr; dat_i = dat; sel_i = sel;
        ack = 1'b0; err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat,
                           output logic ack, output logic err);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = adr; sel_i = 4'hF;
        ack = 1'b0; err = 1'b0; dat = 32'hXXXXXXXX;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; dat = wb_dat_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic a, e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({o_go, wb_ack_o, wb_err_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {o_go, wb_ack_o, wb_err_o}); end
        checks++; if (o_tx_data !== 32'h0) begin failures++; $display("FAIL reset_txdata got %h want 00000000", o_tx_data); end
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h5 || a !== 1'b1) begin failures++; $display("FAIL reset_status got %h ack %b want 00000005 ack 1", d, a); end
        wb_read(2'd2, d, a, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got %h want 00000000", d); end
        wb_write(2'd0, 32'hDEADBEEF, 4'hF, a, e);
        wb_write(2'd2, 32'h1, 4'h1, a, e);
        @(posedge clk); #1;
        checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL pre_reset_go got %b want 1", o_go); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (o_go !== 1'b0 || o_tx_data !== 32'h0) begin failures++; $display("FAIL async_reset go %b data %h want 0 00000000", o_go, o_tx_data); end
        @(negedge clk); rst_n = 1'b1;
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL midbusy_reset_status got %h want 00000005", d); end
        wb_read(2'd2, d, a, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL midbusy_reset_ctrl got %h want 00000000", d); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_regs();
        logic [31:0] d; logic a, e;
        wb_write(2'd3, 32'hFFFFFFFF, 4'hF, a, e);
        checks++; if ({a, e} !== 2'b10) begin failures++; $display("FAIL adr3_write ack/err got %b want 10", {a, e}); end
        wb_read(2'd3, d, a, e);
        checks++; if (d !== 32'h0 || {a, e} !== 2'b10) begin failures++; $display("FAIL adr3_read got %h ack/err %b want 00000000 10", d, {a, e}); end
        wb_write(2'd1, 32'hFFFFFFFF, 4'hF, a, e);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL status_write_ignored got %h want 00000005", d); end
        wb_write(2'd2, 32'hFFFFFFFF, 4'hE, a, e);
        wb_read(2'd2, d, a, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_sel0_low got %h want 00000000", d); end
        wb_write(2'd2, 32'hFFFFFFFF, 4'h1, a, e);
        wb_read(2'd2, d, a, e);
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL ctrl_readback got %h want 00000005", d); end
`else
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL ctrl_readback got %h want 00000001", d); end
`endif
        wb_write(2'd2, 32'h0, 4'h1, a, e);
    endtask

    task automatic test_transfer();
        logic [31:0] d; logic a, e;
        wb_write(2'd0, 32'hA5A5A5A5, 4'hF, a, e);
        wb_write(2'd0, 32'h12345678, 4'h0, a, e);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00000204 || o_go !== 1'b0) begin failures++; $display("FAIL queued_status got %h go %b want 00000204 0", d, o_go); end
        wb_write(2'd2, 32'h1, 4'h1, a, e);
        checks++; if (o_go !== 1'b0) begin failures++; $display("FAIL go_on_en_edge got %b want 0", o_go); end
        @(posedge clk); #1;
        checks++; if (o_go !== 1'b1 || o_tx_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL first_go go %b data %h want 1 a5a5a5a5", o_go, o_tx_data); end
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00000114) begin failures++; $display("FAIL busy_status got %h want 00000114", d); end
        repeat (40) @(posedge clk);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00020001) begin failures++; $display("FAIL done_status got %h want 00020001", d); end
        wb_read(2'd0, d, a, e);
        checks++; if (d !== 32'h5A5A5A5A || {a, e} !== 2'b10) begin failures++; $display("FAIL rx_word1 got %h ack/err %b want 5a5a5a5a 10", d, {a, e}); end
        wb_read(2'd0, d, a, e);
        checks++; if (d !== 32'hEDCBA987 || {a, e} !== 2'b10) begin failures++; $display("FAIL rx_word2 got %h ack/err %b want edcba987 10", d, {a, e}); end
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL drained_status got %h want 00000005", d); end
        wb_write(2'd2, 32'h0, 4'h1, a, e);
    endtask

    task automatic test_full();
        logic [31:0] d; logic a, e;
        for (int i = 0; i < 9; i++) begin
            wb_write(2'd0, 32'h100 + i, 4'hF, a, e);
            checks++;
            if (i < 8 && {a, e} !== 2'b10) begin failures++; $display("FAIL tx_write_%0d ack/err got %b want 10", i, {a, e}); end
            else if (i == 8 && {a, e} !== 2'b01) begin failures++; $display("FAIL tx_overflow ack/err got %b want 01", {a, e}); end
        end
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00000806) begin failures++; $display("FAIL tx_full_status got %h want 00000806", d); end
        wb_read(2'd0, d, a, e);
        checks++; if (d !== 32'h0 || {a, e} !== 2'b01) begin failures++; $display("FAIL rx_underflow got %h ack/err %b want 00000000 01", d, {a, e}); end
        wb_write(2'd2, 32'h2, 4'h1, a, e);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL clr_idle_status got %h want 00000005", d); end
        wb_read(2'd2, d, a, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL clr_reads_zero got %h want 00000000", d); end
    endtask

    task automatic test_rx_full();
        logic [31:0] d; logic a, e;
        int acks = 0;
        wb_write(2'd2, 32'h1, 4'h1, a, e);
        for (int i = 0; i < 10; i++) begin
            wb_write(2'd0, 32'h200 + i, 4'hF, a, e);
            if (a === 1'b1 && e === 1'b0) acks++;
        end
        checks++; if (acks !== 10) begin failures++; $display("FAIL streaming_writes acked %0d want 10", acks); end
        repeat (120) @(posedge clk);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00080208 || o_go !== 1'b0) begin failures++; $display("FAIL rx_full_status got %h go %b want 00080208 0", d, o_go); end
        wb_read(2'd0, d, a, e);
        checks++; if (d !== 32'hFFFFFDFF) begin failures++; $display("FAIL rx_full_head got %h want fffffdff", d); end
        checks++; if (o_go !== 1'b0) begin failures++; $display("FAIL go_on_pop_edge got %b want 0", o_go); end
        @(posedge clk); #1;
        checks++; if (o_go !== 1'b1 || o_tx_data !== 32'h208) begin failures++; $display("FAIL ninth_go go %b data %h want 1 00000208", o_go, o_tx_data); end
        wb_write(2'd2, 32'h0, 4'h1, a, e);
        repeat (15) @(posedge clk);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00080108) begin failures++; $display("FAIL en_off_no_abort got %h want 00080108", d); end
        wb_write(2'd2, 32'h2, 4'h1, a, e);
    endtask

    task automatic test_clr();
        logic [31:0] d; logic a, e;
        int seen_low = 0, go_after = 0;
        for (int i = 0; i < 4; i++) wb_write(2'd0, 32'h300 + i, 4'hF, a, e);
        wb_write(2'd2, 32'h1, 4'h1, a, e);
        @(posedge clk); #1;
        checks++; if (o_go !== 1'b1 || o_tx_data !== 32'h300) begin failures++; $display("FAIL clr_word1_go go %b data %h want 1 00000300", o_go, o_tx_data); end
        repeat (2) @(posedge clk);
        wb_write(2'd2, 32'h3, 4'h1, a, e);
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00000015) begin failures++; $display("FAIL clr_busy_status got %h want 00000015", d); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!o_go) seen_low = 1;
            else if (seen_low != 0) go_after++;
        end
        checks++; if (seen_low !== 1 || go_after !== 0) begin failures++; $display("FAIL clr_no_more_go low %0d later_go %0d want 1 0", seen_low, go_after); end
        wb_read(2'd1, d, a, e);
        checks++; if (d !== 32'h00010001) begin failures++; $display("FAIL clr_rx_status got %h want 00010001", d); end
        wb_read(2'd0, d, a, e);
        checks++; if (d !== 32'hFFFFFCFF) begin failures++; $display("FAIL clr_rx_word got %h want fffffcff", d); end
        wb_write(2'd2, 32'h0, 4'h1, a, e);
    endtask

`ifdef SPI_FIFO_BRIDGE_IRQ_EN
    task automatic test_irq();
        logic [31:0] d; logic a, e;
        wb_write(2'd0, 32'h400, 4'hF, a, e);
        wb_write(2'd2, 32'h5, 4'h1, a, e);
        @(posedge clk); #1;
        checks++; if (wb_int_o !== 1'b0 || o_go !== 1'b1) begin failures++; $display("FAIL irq_busy int %b go %b want 0 1", wb_int_o, o_go); end
        repeat (20) @(posedge clk); #1;
        checks++; if (wb_int_o !== 1'b1) begin failures++; $display("FAIL irq_after_done got %b want 1", wb_int_o); end
        wb_read(2'd0, d, a, e);
        repeat (2) @(posedge clk); #1;
        checks++; if (wb_int_o !== 1'b1) begin failures++; $display("FAIL irq_idle_empty got %b want 1", wb_int_o); end
        wb_write(2'd2, 32'h1, 4'h1, a, e);
        @(posedge clk); #1;
        checks++; if (wb_int_o !== 1'b0) begin failures++; $display("FAIL irq_ie_off got %b want 0", wb_int_o); end
        wb_write(2'd2, 32'h0, 4'h1, a, e);
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_transfer();
        test_full();
        test_rx_full();
        test_clr();
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
